// File: rtl/ps2_mouse_packet_ctrl_if.sv
// Byte-stream input and decoded mouse-packet outputs
// of the PS/2 packet controller.
interface ps2_mouse_packet_ctrl_if #(
  parameter int POS_W = 10
);
  logic [7:0]       i_byte;
  logic             i_byte_valid;
  logic [2:0]       o_buttons;
  logic [8:0]       o_dx;
  logic [8:0]       o_dy;
  logic [POS_W-1:0] o_x;
  logic [POS_W-1:0] o_y;
  logic             o_packet_valid;
  logic             o_sync_err;
  logic             o_timeout;

  modport master (
    output i_byte,
    output i_byte_valid,
    input  o_buttons,
    input  o_dx,
    input  o_dy,
    input  o_x,
    input  o_y,
    input  o_packet_valid,
    input  o_sync_err,
    input  o_timeout
  );

  modport slave (
    input  i_byte,
    input  i_byte_valid,
    output o_buttons,
    output o_dx,
    output o_dy,
    output o_x,
    output o_y,
    output o_packet_valid,
    output o_sync_err,
    output o_timeout
  );
endinterface

// File: rtl/ps2_mouse_packet_ctrl.sv
// Assembles PS/2 bytes into 3-byte mouse packets and
// tracks a clamped cursor position.
module ps2_mouse_packet_ctrl #(
  parameter int SCREEN_W       = 640,
  parameter int SCREEN_H       = 480,
  parameter int POS_W          = 10,
  parameter int X_INIT         = 320,
  parameter int Y_INIT         = 240,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input logic                  i_driver_clk,
  input logic                  rst,
  ps2_mouse_packet_ctrl_if.slave bus
);

  localparam int EW = POS_W + 2;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic signed [EW-1:0] X_MAX =
    EW'(SCREEN_W - 1);
  localparam logic signed [EW-1:0] Y_MAX =
    EW'(SCREEN_H - 1);
  localparam logic [TW-1:0] T_LAST =
    TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_B1,
    WAIT_B2,
    EMIT
  } state_t;

  state_t state;
  state_t state_n;

  logic          prev_valid;
  logic          strobe;
  logic [TW-1:0] cnt;
  logic [TW-1:0] cnt_n;

  // header keeps byte0 without its always-one framing bit:
  // {y_ovf, x_ovf, y_sgn, x_sgn, mid, right, left}
  logic [6:0] hdr;
  logic [7:0] b1;
  logic [7:0] b2;

  logic ld0;
  logic ld1;
  logic ld2;
  logic emit;
  logic sync_n;
  logic tout_n;

  logic [8:0] dx_dec;
  logic [8:0] dy_dec;

  logic signed [EW-1:0] dx_ext;
  logic signed [EW-1:0] dy_ext;
  logic signed [EW-1:0] x_sum;
  logic signed [EW-1:0] y_sum;
  logic [POS_W-1:0]     x_new;
  logic [POS_W-1:0]     y_new;

  logic [2:0]       btn_q;
  logic [8:0]       dx_q;
  logic [8:0]       dy_q;
  logic [POS_W-1:0] x_q;
  logic [POS_W-1:0] y_q;
  logic             pv_q;
  logic             se_q;
  logic             to_q;

  assign strobe = bus.i_byte_valid & ~prev_valid;

  always_ff @(posedge i_driver_clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = '0;
    ld0     = 1'b0;
    ld1     = 1'b0;
    ld2     = 1'b0;
    emit    = 1'b0;
    sync_n  = 1'b0;
    tout_n  = 1'b0;
    unique case (state)
      IDLE, EMIT: begin
        emit    = (state == EMIT);
        state_n = IDLE;
        if (strobe) begin
          if (bus.i_byte[3]) begin
            ld0     = 1'b1;
            state_n = WAIT_B1;
          end else begin
            sync_n = 1'b1;
          end
        end
      end
      WAIT_B1: begin
        if (strobe) begin
          ld1     = 1'b1;
          state_n = WAIT_B2;
        end else if (cnt == T_LAST) begin
          tout_n  = 1'b1;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      WAIT_B2: begin
        if (strobe) begin
          ld2     = 1'b1;
          state_n = EMIT;
        end else if (cnt == T_LAST) begin
          tout_n  = 1'b1;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_comb begin
    dx_dec = hdr[5] ? 9'd0 : {hdr[3], b1};
    dy_dec = hdr[6] ? 9'd0 : {hdr[4], b2};
    dx_ext = {{(EW-9){dx_dec[8]}}, dx_dec};
    dy_ext = {{(EW-9){dy_dec[8]}}, dy_dec};
    x_sum  = $signed({2'b00, x_q}) + dx_ext;
    // screen y grows downward, PS/2 y grows upward
    y_sum  = $signed({2'b00, y_q}) - dy_ext;
    x_new  = x_sum[POS_W-1:0];
    y_new  = y_sum[POS_W-1:0];
    if (x_sum[EW-1]) begin
      x_new = '0;
    end else if (x_sum > X_MAX) begin
      x_new = X_MAX[POS_W-1:0];
    end
    if (y_sum[EW-1]) begin
      y_new = '0;
    end else if (y_sum > Y_MAX) begin
      y_new = Y_MAX[POS_W-1:0];
    end
  end

  always_ff @(posedge i_driver_clk) begin
    if (rst) begin
      prev_valid <= 1'b0;
      cnt        <= '0;
      hdr        <= '0;
      b1         <= '0;
      b2         <= '0;
      btn_q      <= '0;
      dx_q       <= '0;
      dy_q       <= '0;
      x_q        <= POS_W'(X_INIT);
      y_q        <= POS_W'(Y_INIT);
      pv_q       <= 1'b0;
      se_q       <= 1'b0;
      to_q       <= 1'b0;
    end else begin
      prev_valid <= bus.i_byte_valid;
      cnt        <= cnt_n;
      pv_q       <= emit;
      se_q       <= sync_n;
      to_q       <= tout_n;
      if (ld0) begin
        hdr <= {bus.i_byte[7:4], bus.i_byte[2:0]};
      end
      if (ld1) begin
        b1 <= bus.i_byte;
      end
      if (ld2) begin
        b2 <= bus.i_byte;
      end
      if (emit) begin
        btn_q <= hdr[2:0];
        dx_q  <= dx_dec;
        dy_q  <= dy_dec;
        x_q   <= x_new;
        y_q   <= y_new;
      end
    end
  end

  assign bus.o_buttons      = btn_q;
  assign bus.o_dx           = dx_q;
  assign bus.o_dy           = dy_q;
  assign bus.o_x            = x_q;
  assign bus.o_y            = y_q;
  assign bus.o_packet_valid = pv_q;
  assign bus.o_sync_err     = se_q;
  assign bus.o_timeout      = to_q;

endmodule

// File: tb/tb_ps2_mouse_packet_ctrl.sv
// Directed bench for the PS/2 mouse packet controller.
// Timeout shortened so the idle case runs quickly.
module tb_ps2_mouse_packet_ctrl;

  localparam int TO = 20;

  logic clk;
  logic rst;

  int tests;
  int failed;
  int pv_cnt;
  int se_cnt;
  int to_cnt;
  int overlap;
  int pv0;
  int se0;
  int to0;

  ps2_mouse_packet_ctrl_if #(.POS_W(10)) bus ();

  ps2_mouse_packet_ctrl #(
    .SCREEN_W      (640),
    .SCREEN_H      (480),
    .POS_W         (10),
    .X_INIT        (320),
    .Y_INIT        (240),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_driver_clk(clk),
    .rst         (rst),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    pv_cnt  = 0;
    se_cnt  = 0;
    to_cnt  = 0;
    overlap = 0;
  end

  always @(negedge clk) begin
    if (bus.o_packet_valid === 1'b1) pv_cnt++;
    if (bus.o_sync_err === 1'b1) se_cnt++;
    if (bus.o_timeout === 1'b1) to_cnt++;
    if ((32'(bus.o_packet_valid) + 32'(bus.o_sync_err)
         + 32'(bus.o_timeout)) > 1) overlap++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b,
                      input int hold);
    bus.i_byte       = b;
    bus.i_byte_valid = 1'b1;
    tick(hold);
    bus.i_byte_valid = 1'b0;
    tick(2);
  endtask

  task automatic pkt(input logic [7:0] a,
                     input logic [7:0] b,
                     input logic [7:0] c,
                     input int hold);
    send(a, hold);
    send(b, hold);
    send(c, hold);
    tick(3);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic snap();
    pv0 = pv_cnt;
    se0 = se_cnt;
    to0 = to_cnt;
  endtask

  initial begin
    tests            = 0;
    failed           = 0;
    rst              = 1'b1;
    bus.i_byte       = 8'h00;
    bus.i_byte_valid = 1'b0;
    tick(1);
    do_reset();

    chk("rst_x", 32'(bus.o_x), 32'd320);
    chk("rst_y", 32'(bus.o_y), 32'd240);
    chk("rst_btn", 32'(bus.o_buttons), 32'd0);
    chk("rst_dx", 32'(bus.o_dx), 32'd0);
    chk("rst_dy", 32'(bus.o_dy), 32'd0);
    chk("rst_pv", 32'(bus.o_packet_valid), 32'd0);

    // packet 1 with exact latency check on the last byte
    snap();
    send(8'h09, 1);
    send(8'h05, 1);
    bus.i_byte       = 8'h02;
    bus.i_byte_valid = 1'b1;
    tick(1);
    bus.i_byte_valid = 1'b0;
    chk("lat_emit", 32'(bus.o_packet_valid), 32'd0);
    tick(1);
    chk("lat_pulse", 32'(bus.o_packet_valid), 32'd1);
    tick(1);
    chk("lat_one", 32'(bus.o_packet_valid), 32'd0);
    tick(2);
    chk("p1_cnt", 32'(pv_cnt - pv0), 32'd1);
    chk("p1_btn", 32'(bus.o_buttons), 32'b001);
    chk("p1_dx", 32'(bus.o_dx), 32'h005);
    chk("p1_dy", 32'(bus.o_dy), 32'h002);
    chk("p1_x", 32'(bus.o_x), 32'd325);
    chk("p1_y", 32'(bus.o_y), 32'd238);

    // negative deltas, strobe level held 5 cycles
    do_reset();
    snap();
    pkt(8'h38, 8'hFB, 8'hFE, 5);
    chk("p2_cnt", 32'(pv_cnt - pv0), 32'd1);
    chk("p2_se", 32'(se_cnt - se0), 32'd0);
    chk("p2_btn", 32'(bus.o_buttons), 32'd0);
    chk("p2_dx", 32'(bus.o_dx), 32'h1FB);
    chk("p2_dy", 32'(bus.o_dy), 32'h1FE);
    chk("p2_x", 32'(bus.o_x), 32'd315);
    chk("p2_y", 32'(bus.o_y), 32'd242);

    // bad sync byte then a good packet
    do_reset();
    snap();
    send(8'h00, 1);
    tick(2);
    chk("se_cnt", 32'(se_cnt - se0), 32'd1);
    chk("se_nopv", 32'(pv_cnt - pv0), 32'd0);
    pkt(8'h08, 8'h01, 8'h01, 1);
    chk("p3_cnt", 32'(pv_cnt - pv0), 32'd1);
    chk("p3_x", 32'(bus.o_x), 32'd321);
    chk("p3_y", 32'(bus.o_y), 32'd239);

    // partial packet abandoned by timeout
    snap();
    send(8'h08, 1);
    tick(TO - 6);
    chk("to_early", 32'(to_cnt - to0), 32'd0);
    tick(2 * TO);
    chk("to_cnt", 32'(to_cnt - to0), 32'd1);
    chk("to_nopv", 32'(pv_cnt - pv0), 32'd0);
    pkt(8'h08, 8'h00, 8'h00, 1);
    chk("p4_cnt", 32'(pv_cnt - pv0), 32'd1);
    chk("p4_dx", 32'(bus.o_dx), 32'h000);
    chk("p4_x", 32'(bus.o_x), 32'd321);

    // right-edge clamp, then X overflow
    do_reset();
    pkt(8'h08, 8'hFF, 8'h00, 1);
    chk("c1_x", 32'(bus.o_x), 32'd575);
    pkt(8'h08, 8'hFF, 8'h00, 1);
    chk("c2_x", 32'(bus.o_x), 32'd639);
    pkt(8'h08, 8'hFF, 8'h00, 1);
    chk("c3_x", 32'(bus.o_x), 32'd639);
    pkt(8'h48, 8'hFF, 8'h00, 1);
    chk("ov_dx", 32'(bus.o_dx), 32'h000);
    chk("ov_x", 32'(bus.o_x), 32'd639);
    // large upward move clamps y at top
    pkt(8'h08, 8'h00, 8'hFF, 1);
    chk("cy_dy", 32'(bus.o_dy), 32'h0FF);
    chk("cy_y", 32'(bus.o_y), 32'd0);
    // leftward -255
    pkt(8'h18, 8'h01, 8'h00, 1);
    chk("cl_x", 32'(bus.o_x), 32'd384);

    // reset mid-packet drops stale bytes
    send(8'h09, 1);
    send(8'h05, 1);
    do_reset();
    snap();
    pkt(8'h08, 8'h02, 8'h00, 1);
    chk("mr_cnt", 32'(pv_cnt - pv0), 32'd1);
    chk("mr_btn", 32'(bus.o_buttons), 32'd0);
    chk("mr_x", 32'(bus.o_x), 32'd322);
    chk("mr_y", 32'(bus.o_y), 32'd240);

    chk("no_overlap", 32'(overlap), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
